// File: rtl/pmp_pkg.sv
// rtl/pmp_pkg.sv - shared constants and fixed-point position type for the interpolation core
package pmp_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int FRAC_BITS_DEF  = 8;
    localparam int IDX_WIDTH_DEF  = 16;
    localparam int POS_WIDTH_DEF  = DATA_WIDTH_DEF + 1 + FRAC_BITS_DEF;

    // Absolute position: integer part is the widened base, low FRAC_BITS are the fraction
    typedef logic signed [POS_WIDTH_DEF-1:0] pos_t;

endpackage

// File: rtl/interp_core_if.sv
// rtl/interp_core_if.sv - sample-in / result-out signal bundle of the interpolation core
interface interp_core_if import pmp_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int IDX_WIDTH  = IDX_WIDTH_DEF
) ();

    logic signed [DATA_WIDTH-1:0]           x0;
    logic signed [DATA_WIDTH-1:0]           y_sub_y0;
    logic signed [DATA_WIDTH-1:0]           y_sub_y1;
    logic signed [DATA_WIDTH-1:0]           abs_phase1_pos_i;
    logic                                   not_found_i;
    logic                                   tlast_i;
    logic                                   vld_i;

    logic signed [DATA_WIDTH+FRAC_BITS:0]   pos_o;
    logic                                   not_found_o;
    logic                                   no_cross_o;
    logic                                   tlast_o;
    logic                                   vld_o;
    logic        [IDX_WIDTH-1:0]            idx_o;

    modport slave (
        input  x0, y_sub_y0, y_sub_y1, abs_phase1_pos_i, not_found_i, tlast_i, vld_i,
        output pos_o, not_found_o, no_cross_o, tlast_o, vld_o, idx_o
    );

    modport master (
        output x0, y_sub_y0, y_sub_y1, abs_phase1_pos_i, not_found_i, tlast_i, vld_i,
        input  pos_o, not_found_o, no_cross_o, tlast_o, vld_o, idx_o
    );

endinterface

// File: rtl/div_stage.sv
// rtl/div_stage.sv - one restoring-division step: shift, compare, subtract, emit quotient bit
module div_stage import pmp_pkg::*; #(
    parameter int R_WIDTH = DATA_WIDTH_DEF + 1,
    parameter int Q_WIDTH = FRAC_BITS_DEF
) (
    input  logic [R_WIDTH-1:0] r_in,
    input  logic [R_WIDTH-1:0] den,
    input  logic [Q_WIDTH-1:0] q_in,
    output logic [R_WIDTH-1:0] r_out,
    output logic [Q_WIDTH-1:0] q_out
);

    logic [R_WIDTH-1:0] r_sh;
    logic               ge;

    // r_in < den <= 2^(R_WIDTH-1)-1, so the doubled remainder never loses its top bit
    always_comb begin
        r_sh  = r_in << 1;
        ge    = (r_sh >= den);
        r_out = ge ? (r_sh - den) : r_sh;
        q_out = (q_in << 1) | Q_WIDTH'(ge);
    end

endmodule

// File: rtl/interp_core.sv
// rtl/interp_core.sv - pipelined sub-sample crossing interpolator with per-frame point index
module interp_core import pmp_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int IDX_WIDTH  = IDX_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    interp_core_if.slave  bus
);

    localparam int R_W   = DATA_WIDTH + 1;
    localparam int POS_W = DATA_WIDTH + 1 + FRAC_BITS;
    localparam int NS    = FRAC_BITS;

    // Index 0 is the input register; index i+1 holds the result of divider step i
    logic        [R_W-1:0]       r_q    [0:NS];
    logic        [R_W-1:0]       r_d    [0:NS];
    logic        [R_W-1:0]       den_q  [0:NS];
    logic        [R_W-1:0]       den_d  [0:NS];
    logic        [FRAC_BITS-1:0] qp_q   [0:NS];
    logic        [FRAC_BITS-1:0] qp_d   [0:NS];
    logic signed [R_W-1:0]       base_q [0:NS];
    logic signed [R_W-1:0]       base_d [0:NS];

    logic        [R_W-1:0]       r_step [0:NS-1];
    logic        [FRAC_BITS-1:0] q_step [0:NS-1];

    logic [NS:0] vld_q, vld_d;
    logic [NS:0] nf_q,  nf_d;
    logic [NS:0] nc_q,  nc_d;
    logic [NS:0] tl_q,  tl_d;

    logic signed [POS_W-1:0]     pos_q, pos_d;
    logic                        nf_o_q, nf_o_d;
    logic                        nc_o_q, nc_o_d;
    logic                        tl_o_q, tl_o_d;
    logic                        vld_o_q, vld_o_d;
    logic        [IDX_WIDTH-1:0] idx_q, idx_d;
    logic        [IDX_WIDTH-1:0] idx_next_q, idx_next_d;

    logic signed [R_W-1:0]       y0_ext, y1_ext, base_in;
    logic        [R_W-1:0]       den_in;
    logic                        cross_in, div_ok, fire;

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_div
            div_stage #(
                .R_WIDTH (R_W),
                .Q_WIDTH (FRAC_BITS)
            ) u_div_stage (
                .r_in  (r_q[gi]),
                .den   (den_q[gi]),
                .q_in  (qp_q[gi]),
                .r_out (r_step[gi]),
                .q_out (q_step[gi])
            );
        end
    endgenerate

    always_comb begin
        y0_ext   = {bus.y_sub_y0[DATA_WIDTH-1], bus.y_sub_y0};
        y1_ext   = {bus.y_sub_y1[DATA_WIDTH-1], bus.y_sub_y1};
        base_in  = {bus.abs_phase1_pos_i[DATA_WIDTH-1], bus.abs_phase1_pos_i}
                 + {bus.x0[DATA_WIDTH-1], bus.x0};
        den_in   = y0_ext - y1_ext;
        cross_in = !bus.y_sub_y0[DATA_WIDTH-1] && bus.y_sub_y1[DATA_WIDTH-1];
        div_ok   = cross_in && !bus.not_found_i;
    end

    // A zero dividend with a unit divisor makes the divider emit q=0 for rejected samples
    always_comb begin
        r_d[0]    = div_ok ? y0_ext : '0;
        den_d[0]  = div_ok ? den_in : R_W'(1);
        qp_d[0]   = '0;
        base_d[0] = base_in;
        for (int i = 0; i < NS; i++) begin
            r_d[i+1]    = r_step[i];
            den_d[i+1]  = den_q[i];
            qp_d[i+1]   = q_step[i];
            base_d[i+1] = base_q[i];
        end
        vld_d = {vld_q[NS-1:0], bus.vld_i};
        nf_d  = {nf_q[NS-1:0],  bus.not_found_i};
        nc_d  = {nc_q[NS-1:0],  !bus.not_found_i && !cross_in};
        tl_d  = {tl_q[NS-1:0],  bus.tlast_i};
    end

    always_ff @(posedge clk) begin
        r_q    <= r_d;
        den_q  <= den_d;
        qp_q   <= qp_d;
        base_q <= base_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            nf_q  <= '0;
            nc_q  <= '0;
            tl_q  <= '0;
        end else begin
            vld_q <= vld_d;
            nf_q  <= nf_d;
            nc_q  <= nc_d;
            tl_q  <= tl_d;
        end
    end

    always_comb begin
        fire       = vld_q[NS];
        pos_d      = pos_q;
        nf_o_d     = nf_o_q;
        nc_o_d     = nc_o_q;
        idx_d      = idx_q;
        idx_next_d = idx_next_q;
        vld_o_d    = fire;
        tl_o_d     = fire && tl_q[NS];
        if (fire) begin
            pos_d      = {base_q[NS], {FRAC_BITS{1'b0}}} + POS_W'(qp_q[NS]);
            nf_o_d     = nf_q[NS];
            nc_o_d     = nc_q[NS];
            idx_d      = idx_next_q;
            idx_next_d = tl_q[NS] ? '0 : idx_next_q + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q      <= '0;
            nf_o_q     <= 1'b0;
            nc_o_q     <= 1'b0;
            tl_o_q     <= 1'b0;
            vld_o_q    <= 1'b0;
            idx_q      <= '0;
            idx_next_q <= '0;
        end else begin
            pos_q      <= pos_d;
            nf_o_q     <= nf_o_d;
            nc_o_q     <= nc_o_d;
            tl_o_q     <= tl_o_d;
            vld_o_q    <= vld_o_d;
            idx_q      <= idx_d;
            idx_next_q <= idx_next_d;
        end
    end

    assign bus.pos_o       = pos_q;
    assign bus.not_found_o = nf_o_q;
    assign bus.no_cross_o  = nc_o_q;
    assign bus.tlast_o     = tl_o_q;
    assign bus.vld_o       = vld_o_q;
    assign bus.idx_o       = idx_q;

endmodule

// File: tb/tb_interp_core.sv
// tb/tb_interp_core.sv - self-checking bench for interp_core
module tb_interp_core;
    import pmp_pkg::*;

    typedef struct {
        int     x0;
        int     abs_p;
        int     y0;
        int     y1;
        int     nf;
        int     tl;
        int     nc;
        longint pos;
        int     idx;
    } vec_t;

    typedef struct {
        longint pos;
        int     nf;
        int     nc;
        int     tl;
        int     idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vecs [9];
    exp_t q_exp [$];

    always #5 clk = ~clk;

    interp_core_if #(.DATA_WIDTH(16), .FRAC_BITS(8), .IDX_WIDTH(16)) bus ();

    interp_core #(.DATA_WIDTH(16), .FRAC_BITS(8), .IDX_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.vld_i            = 1'b0;
        bus.tlast_i          = 1'b0;
        bus.not_found_i      = 1'b0;
        bus.x0               = '0;
        bus.abs_phase1_pos_i = '0;
        bus.y_sub_y0         = '0;
        bus.y_sub_y1         = '0;
    endtask

    task automatic set_in(input int x0, input int ab, input int y0, input int y1,
                          input int nf, input int tl);
        bus.vld_i            = 1'b1;
        bus.x0               = 16'(x0);
        bus.abs_phase1_pos_i = 16'(ab);
        bus.y_sub_y0         = 16'(y0);
        bus.y_sub_y1         = 16'(y1);
        bus.not_found_i      = 1'(nf);
        bus.tlast_i          = 1'(tl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pos"},  bus.pos_o, 0);
        chk({tag, "_idx"},  bus.idx_o, 0);
        chk({tag, "_vld"},  bus.vld_o, 0);
        chk({tag, "_tl"},   bus.tlast_o, 0);
        chk({tag, "_nf"},   bus.not_found_o, 0);
        chk({tag, "_nc"},   bus.no_cross_o, 0);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        @(negedge clk);
        set_in(v.x0, v.abs_p, v.y0, v.y1, v.nf, v.tl);
        @(negedge clk);
        idle();
        repeat (8) @(negedge clk);
        chk({tag, "_vld_early"}, bus.vld_o, 0);
        @(negedge clk);
        chk({tag, "_vld"}, bus.vld_o, 1);
        chk({tag, "_pos"}, bus.pos_o, v.pos);
        chk({tag, "_nf"},  bus.not_found_o, v.nf);
        chk({tag, "_nc"},  bus.no_cross_o, v.nc);
        chk({tag, "_tl"},  bus.tlast_o, v.tl);
        chk({tag, "_idx"}, bus.idx_o, v.idx);
        @(negedge clk);
        chk({tag, "_vld_drop"}, bus.vld_o, 0);
        chk({tag, "_tl_drop"},  bus.tlast_o, 0);
        chk({tag, "_pos_hold"}, bus.pos_o, v.pos);
        chk({tag, "_idx_hold"}, bus.idx_o, v.idx);
    endtask

    initial begin
        int   exp_idx [6];
        int   seen;
        int   cnt;
        int   n;
        exp_t e;

        vecs[0] = '{10, 100, 3, -1, 0, 0, 0, 28352, 0};
        vecs[1] = '{0, 0, 32767, -32768, 0, 1, 0, 127, 1};
        vecs[2] = '{5, -20, 0, -5, 0, 0, 0, -3840, 0};
        vecs[3] = '{7, 3, 5, 2, 0, 0, 1, 2560, 1};
        vecs[4] = '{1, 1, 3, -1, 1, 1, 0, 512, 2};
        vecs[5] = '{32767, 32767, 1, -1, 0, 1, 0, 16776832, 0};
        vecs[6] = '{-32768, -32768, -3, -4, 0, 0, 1, -16777216, 0};
        vecs[7] = '{0, 0, 1, -2, 0, 1, 0, 85, 1};
        vecs[8] = '{-1, 0, 0, 0, 0, 0, 1, -256, 0};
        exp_idx = '{0, 1, 2, 3, 0, 1};

        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back samples spanning a frame boundary
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            set_in(k, 0, 1, -1, 0, (k == 3) ? 1 : 0);
        end
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        chk("seq_vld_early", bus.vld_o, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("seq%0d_vld", k), bus.vld_o, 1);
            chk($sformatf("seq%0d_idx", k), bus.idx_o, exp_idx[k]);
            chk($sformatf("seq%0d_tl", k),  bus.tlast_o, (k == 3) ? 1 : 0);
            chk($sformatf("seq%0d_pos", k), bus.pos_o, k * 256 + 128);
        end
        @(negedge clk);
        chk("seq_vld_end", bus.vld_o, 0);

        // Reset in the middle of a burst flushes everything in flight
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_in(k + 20, 0, 3, -1, 0, 0);
        end
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("flush");
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.vld_o) seen++;
        end
        chk("flush_no_vld", seen, 0);
        apply_vec(vecs[0], "post_rst");

        // Random crossings against an integer-division reference model
        do_reset();
        cnt = 0;
        n = 0;
        while (n < 10000) begin
            @(negedge clk);
            if (bus.vld_o) begin
                if (q_exp.size() == 0) begin
                    chk("rnd_unexpected_vld", 1, 0);
                end else begin
                    e = q_exp.pop_front();
                    chk("rnd_pos", bus.pos_o, e.pos);
                    chk("rnd_nf",  bus.not_found_o, e.nf);
                    chk("rnd_nc",  bus.no_cross_o, e.nc);
                    chk("rnd_tl",  bus.tlast_o, e.tl);
                    chk("rnd_idx", bus.idx_o, e.idx);
                end
            end else begin
                chk("rnd_tl_idle", bus.tlast_o, 0);
            end
            if ($urandom_range(0, 3) != 0) begin
                int x0, ab, y0, y1, nf, tl, q, base;
                x0 = int'($urandom_range(0, 65535)) - 32768;
                ab = int'($urandom_range(0, 65535)) - 32768;
                if ($urandom_range(0, 3) != 0) begin
                    y0 = int'($urandom_range(0, 32767));
                    y1 = -int'($urandom_range(1, 32768));
                end else begin
                    y0 = int'($urandom_range(0, 65535)) - 32768;
                    y1 = int'($urandom_range(0, 65535)) - 32768;
                end
                nf = ($urandom_range(0, 15) == 0) ? 1 : 0;
                tl = ($urandom_range(0, 15) == 0) ? 1 : 0;
                set_in(x0, ab, y0, y1, nf, tl);
                base = ab + x0;
                q = 0;
                e.nc = 0;
                if (nf == 0) begin
                    if (y0 >= 0 && y1 < 0) q = (y0 * 256) / (y0 - y1);
                    else e.nc = 1;
                end
                e.pos = longint'(base) * 256 + q;
                e.nf  = nf;
                e.tl  = tl;
                e.idx = cnt;
                cnt   = (tl != 0) ? 0 : (cnt + 1) % 65536;
                q_exp.push_back(e);
                n++;
            end else begin
                idle();
            end
        end
        @(negedge clk);
        idle();
        repeat (12) begin
            if (bus.vld_o) begin
                if (q_exp.size() == 0) begin
                    chk("rnd_unexpected_vld", 1, 0);
                end else begin
                    e = q_exp.pop_front();
                    chk("rnd_pos", bus.pos_o, e.pos);
                    chk("rnd_idx", bus.idx_o, e.idx);
                end
            end
            @(negedge clk);
        end
        chk("rnd_drain", q_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/interp_core.md
INTERP_CORE -- requirements
Module: interp_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 16, width of search-stage samples and positions.
REQ-002 SHALL have parameter FRAC_BITS, 8, fractional bits of the interpolated position.
REQ-003 SHALL have parameter IDX_WIDTH, 16, width of the per-frame point index.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports x0, y_sub_y0, y_sub_y1  input  DATA_WIDTH signed  bracketing position and errors from the search stage.
REQ-007 SHALL have port abs_phase1_pos_i  input  DATA_WIDTH signed  absolute phase-1 window base.
REQ-008 SHALL have ports not_found_i, tlast_i, vld_i  input  1 each  search flags, end-of-frame, sample valid.
REQ-009 SHALL have port pos_o  output  DATA_WIDTH+1+FRAC_BITS signed  interpolated absolute position, fixed point with FRAC_BITS fractional bits.
REQ-010 SHALL have ports not_found_o, no_cross_o, tlast_o, vld_o  output  1 each.
REQ-011 SHALL have port idx_o  output  IDX_WIDTH unsigned  index of the point within the current frame.

Function
REQ-012 SHALL accept one sample per cycle whenever vld_i=1; there is no backpressure, and the block never stalls.
REQ-013 SHALL produce each result exactly FRAC_BITS+2 cycles after the accepted sample, in order: 1 input register stage, FRAC_BITS divider stages, 1 output stage.
REQ-014 SHALL compute base = abs_phase1_pos_i + x0, sign-extended to DATA_WIDTH+1 bits so that no overflow occurs.
REQ-015 SHALL define a valid crossing as y_sub_y0 >= 0 and y_sub_y1 < 0, with den = y_sub_y0 - y_sub_y1 computed at DATA_WIDTH+1 bits (always > 0).
REQ-016 SHALL compute q = floor(y_sub_y0 * 2^FRAC_BITS / den) for a valid crossing.
- Unsigned restoring division, one quotient bit per stage, MSB first.
- Remainder width DATA_WIDTH+1.
- Result range 0 <= q <= 2^FRAC_BITS-1; no clamp is needed.
REQ-017 SHALL force q=0 and no_cross_o=1 when the crossing condition fails and not_found_i=0.
REQ-018 SHALL force q=0 and no_cross_o=0 when not_found_i=1, with not_found_o=1 passed through.
REQ-019 SHALL output pos_o = (base << FRAC_BITS) + q.
REQ-020 SHALL carry not_found, tlast, the no-cross flag and base through a side-band shift register aligned with the divider pipeline.
REQ-021 SHALL update outputs only when vld_o=1; when vld_o=0, pos_o, flags and idx_o hold their last values and tlast_o=0.
REQ-022 SHALL apply these idx_o counter rules:
- 0 for the first output after reset or after an output with tlast_o=1.
- Increments by 1 per output.
- Wraps from 2^IDX_WIDTH-1 to 0.
REQ-023 SHALL treat tlast_i on consecutive valid samples (one-point frames) correctly: each such output has idx_o=0.

Reset
REQ-024 SHALL asynchronously clear, when rst=1, vld_o, tlast_o, not_found_o, no_cross_o, pos_o, idx_o and all pipeline valid bits to 0.
REQ-025 SHALL discard samples in flight when reset is asserted mid-operation; none of them produce vld_o after reset is released.
REQ-026 SHALL leave divider datapath registers unreset; only valid, control and output registers are reset.

Structure
REQ-027 SHALL place the default DATA_WIDTH and FRAC_BITS constants and the fixed-point position typedef in shared package pmp_pkg.
REQ-028 SHALL implement one restoring-division step (compare, subtract, shift, quotient bit) as sub-module div_stage, instantiated FRAC_BITS times in a generate loop.

Verification (DATA_WIDTH=16, FRAC_BITS=8, latency 10)
REQ-029 SHALL cover: x0=10, abs=100, y0=3, y1=-1 -> 10 cycles later vld_o=1, pos_o=28352 (110*256+192), no_cross_o=0.
REQ-030 SHALL cover: y0=32767, y1=-32768, x0=0, abs=0 -> pos_o=127; y0=0, y1=-5 -> q=0, pos_o=base*256, no_cross_o=0.
REQ-031 SHALL cover: y0=5, y1=2 -> no_cross_o=1, q=0; not_found_i=1 with any y -> not_found_o=1, no_cross_o=0, q=0.
REQ-032 SHALL cover: 4 back-to-back samples, tlast_i on the 4th, then 2 more -> idx_o 0,1,2,3 (tlast_o on 3), then 0,1; outputs on consecutive cycles.
REQ-033 SHALL cover: rst pulsed 3 cycles after a vld_i burst -> all outputs 0 immediately and no vld_o for the flushed samples; the next sample has idx_o=0.
REQ-034 SHALL cover: random crossings over 10k samples checked against a reference model of q and pos_o, with vld_i gaps inserted randomly.
